// File: rtl/target_motion.sv
// target_motion: paces one target sprite with a frame tick, bounces its position
// inside the screen and respawns it at an LFSR-derived spot after a hit.
module target_motion #(
  parameter int          TICK_COUNT = 833333,
  parameter int          X_MAX      = 128,
  parameter int          Y_MAX      = 88,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       done,
  input  logic       hit,
  output logic       active,
  output logic       start,
  output logic [7:0] x_set,
  output logic [6:0] y_set
);
  localparam int CW = TICK_COUNT > 1 ? $clog2(TICK_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_COUNT - 1);
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);
  typedef enum logic [1:0] {IDLE, STEP, START, HOLD} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   lfsr_q;
  logic [7:0]    x_q, x_b, x_r;
  logic [6:0]    y_q, y_b, y_r;
  logic [1:0]    hold_q;
  logic          tick_pend_q, respawn_pend_q, dx_q, dy_q, active_q, start_q;
  logic          tick, go;
  assign tick = enable && cnt_q == CNT_LAST;
  // a tick on the same cycle counts as pending, giving the 2-cycle start latency
  assign go = state_q == IDLE && (tick || tick_pend_q) && done && enable;
  always_comb begin
    x_b = dx_q ? (x_q == XM ? XM - 8'd1 : x_q + 8'd1) : (x_q == '0 ? 8'd1 : x_q - 8'd1);
    y_b = dy_q ? (y_q == YM ? YM - 7'd1 : y_q + 7'd1) : (y_q == '0 ? 7'd1 : y_q - 7'd1);
    x_r = lfsr_q[7:0] > XM ? lfsr_q[7:0] - (XM + 8'd1) : lfsr_q[7:0];
    y_r = lfsr_q[14:8] > YM ? lfsr_q[14:8] - (YM + 7'd1) : lfsr_q[14:8];
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lfsr_q         <= SEED;
      x_q            <= '0;
      y_q            <= '0;
      dx_q           <= 1'b1;
      dy_q           <= 1'b1;
      hold_q         <= '0;
      tick_pend_q    <= 1'b0;
      respawn_pend_q <= 1'b0;
      active_q       <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      active_q       <= enable;
      lfsr_q         <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      cnt_q          <= (!enable || tick) ? '0 : cnt_q + 1'b1;
      tick_pend_q    <= !go && (tick || tick_pend_q);
      respawn_pend_q <= hit || (respawn_pend_q && state_q != STEP);
      start_q        <= state_q == STEP;
      case (state_q)
        IDLE: if (go) state_q <= STEP;
        STEP: begin
          state_q <= START;
          x_q     <= respawn_pend_q ? x_r : x_b;
          y_q     <= respawn_pend_q ? y_r : y_b;
          dx_q    <= respawn_pend_q ? lfsr_q[15] : (dx_q ? x_q != XM : x_q == '0);
          dy_q    <= respawn_pend_q ? lfsr_q[0] : (dy_q ? y_q != YM : y_q == '0);
        end
        START: begin
          state_q <= HOLD;
          hold_q  <= '0;
        end
        HOLD: begin
          hold_q <= hold_q + 1'b1;
          if (!done || hold_q == 2'd3) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign active = active_q;
  assign start  = start_q;
  assign x_set  = x_q;
  assign y_set  = y_q;
endmodule

// File: tb/tb_target_motion.sv
// tb_target_motion: scoreboard bench; stimulus queues the kind of each expected
// step (bounce or respawn) and a monitor checks position on every start pulse.
module tb_target_motion;
  logic       clk = 0, rst = 1, enable = 0, done = 1, hit = 0;
  logic       active, start;
  logic [7:0] x;
  logic [6:0] y;
  int         n_chk = 0, n_err = 0, cyc = 0, n_start = 0, last_cyc = 0, en_cyc = 0, s = 0;
  bit         have_last = 0, chk_per = 0;
  int         mx = 0, my = 0, vx = 1, vy = 1;
  logic [15:0] ml, ml_prev;
  bit         sb[$];

  always #5 clk = ~clk;

  target_motion #(.TICK_COUNT(10)) dut (
    .CLOCK_50(clk), .reset(rst), .enable(enable), .done(done), .hit(hit),
    .active(active), .start(start), .x_set(x), .y_set(y)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_empty(input int budget, input string tag);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check(tag, sb.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst)
    if (rst) begin
      ml      <= 16'hACE1;
      ml_prev <= 16'hACE1;
    end else begin
      ml_prev <= ml;
      ml      <= {ml[14:0], ^(ml & 16'hB400)};
    end

  // ml_prev holds the LFSR value seen during STEP, one cycle before start
  always @(negedge clk) begin
    if (rst) begin
      mx = 0; my = 0; vx = 1; vy = 1; have_last = 0;
    end else if (start) begin
      n_start++;
      if (chk_per && have_last) check("period", cyc - last_cyc, 10);
      last_cyc = cyc;
      have_last = 1;
      if (sb.size() == 0) check("unexpected_start", 1, 0);
      else begin
        if (sb.pop_front()) begin
          mx = int'(ml_prev[7:0]);
          if (mx > 128) mx -= 129;
          my = int'(ml_prev[14:8]);
          if (my > 88) my -= 89;
          vx = ml_prev[15] ? 1 : -1;
          vy = ml_prev[0] ? 1 : -1;
        end else begin
          mx += vx;
          if (mx > 128) begin mx = 127; vx = -1; end
          else if (mx < 0) begin mx = 1; vx = 1; end
          my += vy;
          if (my > 88) begin my = 87; vy = -1; end
          else if (my < 0) begin my = 1; vy = 1; end
        end
        check("x_set", int'(x), mx);
        check("y_set", int'(y), my);
        check("in_range", int'(x <= 8'd128 && y <= 7'd88), 1);
      end
    end
  end

  initial begin
    @(negedge clk);
    check("rst_start", start, 0);
    check("rst_active", active, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    rst = 0;
    @(negedge clk);
    check("active_off", active, 0);
    // bounce: long enough to reach y=88, x=128 and x back to 0
    repeat (270) sb.push_back(0);
    chk_per = 1;
    enable = 1;
    en_cyc = cyc;
    @(posedge clk); #1;
    check("active_on", active, 1);
    for (int i = 0; i < 30 && n_start == 0; i++) begin
      @(negedge clk); #1;
    end
    check("first_lat", cyc - en_cyc, 11);
    wait_empty(2800, "bounce_done");
    chk_per = 0;
    // handshake: done low across several ticks collapses into one step
    done = 0;
    s = n_start;
    repeat (35) @(negedge clk);
    #1;
    check("hs_held", n_start, s);
    sb.push_back(0);
    done = 1;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("hs_lat", start, 1);
    enable = 0;
    @(posedge clk); #1;
    check("active_drop", active, 0);
    repeat (40) @(negedge clk);
    #1;
    check("hs_one_start", n_start, s + 1);
    check("sb_empty", sb.size(), 0);
    // respawn
    hit = 1;
    @(negedge clk); #1;
    hit = 0;
    sb.push_back(1);
    repeat (20) sb.push_back(0);
    enable = 1;
    wait_empty(400, "respawn_done");
    // reset while start is high
    sb.push_back(0);
    wait_empty(40, "pre_reset");
    rst = 1;
    #1;
    check("mid_rst_start", start, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    @(negedge clk); #1;
    check("mid_rst_active", active, 0);
    rst = 0;
    repeat (3) sb.push_back(0);
    wait_empty(100, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/target_motion.md
# target_motion

Upstream position/timing controller for one target sprite in the shooter game. It generates the frame tick that paces target motion and issues the single-cycle `start` pulse to the target renderer when that renderer reports `done`. It also supplies the bouncing `x_set`/`y_set` position the renderer latches during its update state. When the target is hit, it respawns the target at a pseudo-random on-screen position.

## Interface
Parameters:
- `TICK_COUNT`, 833333: clock cycles per motion frame (60 Hz at 50 MHz).
- `X_MAX`, 128: largest legal `x_set` (160 − 32 sprite width).
- `Y_MAX`, 88: largest legal `y_set` (120 − 32 sprite height).
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `CLOCK_50`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: game running; gates ticks and drives `active`.
- `done`, in, 1: renderer idle after plotting (its wait state).
- `hit`, in, 1: one-cycle pulse when the score for this target increments.
- `active`, out, 1: registered copy of `enable`.
- `start`, out, 1: one-cycle pulse requesting erase, reload and redraw.
- `x_set`, out, 8: next upper-left X.
- `y_set`, out, 7: next upper-left Y.

## Operation
- **Tick counter**
  - Counts 0..TICK_COUNT−1 while `enable` is high; otherwise holds at 0.
  - `tick` is asserted on the wrap cycle.
  - A tick sets `tick_pend`. `tick_pend` is cleared on entering `STEP`.
- **Hit latch**
  - `hit` sets `respawn_pend`. It is cleared in `STEP`.
  - A `hit` in the same cycle as `STEP` sets the latch again, so it is not lost.
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11. Advances every cycle, including while disabled.
- **FSM states:** `IDLE`, `STEP`, `START`, `HOLD`.
  - `IDLE` → `STEP` when `tick_pend && done && enable`.
  - `STEP` → `START`. Position and velocity are updated at the `STEP` edge.
  - `START` → `HOLD`. `start` = 1 in this state only.
  - `HOLD` → `IDLE` once `done` = 0. `HOLD` also times out to `IDLE` after 4 cycles if `done` stays high, so a renderer that is not listening does not deadlock the block.
- **Bounce update in STEP** (no respawn pending). `dx`/`dy` are 1-bit direction flags, 1 = increasing. X rule:
  - `dx`=1 and `x_set`<`X_MAX`: `x_set`+1.
  - `dx`=1 and `x_set`=`X_MAX`: `dx`←0, `x_set`←`X_MAX`−1.
  - `dx`=0 and `x_set`>0: `x_set`−1.
  - `dx`=0 and `x_set`=0: `dx`←1, `x_set`←1.
  - Y follows the same rule with `Y_MAX`.
- **Respawn update in STEP** (respawn pending):
  - `x_set` ← `lfsr[7:0]` if ≤ `X_MAX`, else `lfsr[7:0]`−(`X_MAX`+1).
  - `y_set` ← `lfsr[14:8]` if ≤ `Y_MAX`, else `lfsr[14:8]`−(`Y_MAX`+1).
  - `dx` ← `lfsr[15]`, `dy` ← `lfsr[0]`.
- **Ranges:** `x_set` and `y_set` are never outside 0..`X_MAX` / 0..`Y_MAX`.
- **Output stability:** outputs change only at the `STEP` edge. The renderer latches them ≥1025 cycles later, in its update state.

## Timing
- **Reset values:**
  - Outputs: `start`=0, `active`=0, `x_set`=0, `y_set`=0.
  - Internal: `dx`=1, `dy`=1, counter=0, both pend latches=0, LFSR=`SEED`, state=`IDLE`.
- **`active`:** follows `enable` with 1-cycle latency.
- **Start latency:** with `done` high, `start` rises 2 cycles after the tick cycle (tick → `IDLE` sees pend → `STEP` → `START`).
- **Pending ticks:** a tick arriving while `done`=0 stays pending. `start` issues 2 cycles after `done` rises. Multiple pending ticks collapse into one step.
- **Enable drop:** `enable` falling mid-sequence lets `STEP`/`START`/`HOLD` complete. No new step is taken until `enable` is high again.
- **Mid-operation reset:** reset asserted mid-sequence forces `start` low immediately (async) and all reset values.

## Test plan
- **Bounce:** `TICK_COUNT`=10, `done`=1, `enable`=1, no hits. Expect `start` pulses every 10 cycles (after an initial 2-cycle latency), `x_set`/`y_set` = 1,2,3…. At `y_set`=88, expect next 87, then 86.
- **X wrap:** force the position to (128, 5) with `dx`=1. Expect next step (127, 6), then `dx` stays 0 through 0. At 0 expect the next value 1.
- **Handshake:** hold `done`=0 across 3 ticks, then raise it. Expect exactly one `start`, 2 cycles later, and one position step. Drop `done` the cycle after `start`; expect `HOLD`→`IDLE`.
- **Respawn:** pulse `hit`. Expect the next step to load a reduced LFSR value. Compare against a model started from `SEED` 16'hACE1: values within 0..128 / 0..88.
- **Enable/reset:** `enable`=0 → no `start` and `active`=0 within 1 cycle. Assert `reset` during `START` → `start`=0 in the same cycle, `x_set`=0, `y_set`=0.
